// File: rtl/snake_prey_gen.sv
// Prey-position generator: draws LFSR cells folded into the playfield and retries
// them against the snake-body occupancy checker until a free cell is found.
module snake_prey_gen #(
  parameter int unsigned                 H_LOGIC_WIDTH = 5,
  parameter int unsigned                 V_LOGIC_WIDTH = 5,
  parameter logic [H_LOGIC_WIDTH-1:0]    H_LOGIC_MAX   = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0]    V_LOGIC_MAX   = 5'd23,
  parameter logic [15:0]                 LFSR_SEED     = 16'hACE1,
  parameter int unsigned                 MAX_TRIES     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  output logic                     cand_valid,
  output logic [H_LOGIC_WIDTH-1:0] candx,
  output logic [V_LOGIC_WIDTH-1:0] candy,
  input  logic                     occ_valid,
  input  logic                     occ_hit,
  output logic                     busy,
  output logic                     prey_valid,
  output logic [H_LOGIC_WIDTH-1:0] preyx,
  output logic [V_LOGIC_WIDTH-1:0] preyy,
  output logic                     fail
);

  localparam int unsigned H      = H_LOGIC_WIDTH;
  localparam int unsigned V      = V_LOGIC_WIDTH;
  localparam int unsigned LFSR_W = 16;
  localparam int unsigned TRY_W  = 8;

  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [H:0]        X_SPAN    = {1'b0, H_LOGIC_MAX} + {{H{1'b0}}, 1'b1};
  localparam logic [V:0]        Y_SPAN    = {1'b0, V_LOGIC_MAX} + {{V{1'b0}}, 1'b1};
  localparam logic [TRY_W-1:0]  TRY_LIMIT = TRY_W'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LFSR_W-1:0] lfsr;
  logic [H:0]        raw_x;
  logic [V:0]        raw_y;
  logic [H-1:0]      fold_x;
  logic [V-1:0]      fold_y;
  logic [TRY_W-1:0]  tries;
  logic [TRY_W-1:0]  tries_nxt;
  logic              last_try;

  logic              cand_valid_nxt;
  logic [H-1:0]      candx_nxt;
  logic [V-1:0]      candy_nxt;
  logic              prey_valid_nxt;
  logic [H-1:0]      preyx_nxt;
  logic [V-1:0]      preyy_nxt;
  logic              fail_nxt;

  // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : '0);
    end
  end

  // One subtraction suffices because the legal range covers at least half the raw range.
  assign raw_x  = {1'b0, lfsr[H-1:0]};
  assign raw_y  = {1'b0, lfsr[H+V-1:H]};
  assign fold_x = (raw_x >= X_SPAN) ? H'(raw_x - X_SPAN) : lfsr[H-1:0];
  assign fold_y = (raw_y >= Y_SPAN) ? V'(raw_y - Y_SPAN) : lfsr[H+V-1:H];

  assign last_try = ((tries + TRY_W'(1)) == TRY_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req) state_nxt = GEN;
      GEN:     state_nxt = CHECK;
      CHECK: begin
        if (occ_valid) begin
          state_nxt = (!occ_hit || last_try) ? IDLE : GEN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and the try counter
  always_comb begin
    tries_nxt      = tries;
    cand_valid_nxt = cand_valid;
    candx_nxt      = candx;
    candy_nxt      = candy;
    prey_valid_nxt = prey_valid;
    preyx_nxt      = preyx;
    preyy_nxt      = preyy;
    fail_nxt       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          tries_nxt      = '0;
          prey_valid_nxt = 1'b0;
        end
      end
      GEN: begin
        candx_nxt      = fold_x;
        candy_nxt      = fold_y;
        cand_valid_nxt = 1'b1;
      end
      CHECK: begin
        if (occ_valid) begin
          cand_valid_nxt = 1'b0;
          if (!occ_hit) begin
            preyx_nxt      = candx;
            preyy_nxt      = candy;
            prey_valid_nxt = 1'b1;
          end else begin
            tries_nxt = tries + TRY_W'(1);
            fail_nxt  = last_try;
          end
        end
      end
      default: begin
        cand_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tries      <= '0;
      cand_valid <= 1'b0;
      candx      <= '0;
      candy      <= '0;
      busy       <= 1'b0;
      prey_valid <= 1'b0;
      preyx      <= '0;
      preyy      <= '0;
      fail       <= 1'b0;
    end else begin
      tries      <= tries_nxt;
      cand_valid <= cand_valid_nxt;
      candx      <= candx_nxt;
      candy      <= candy_nxt;
      busy       <= (state_nxt != IDLE);
      prey_valid <= prey_valid_nxt;
      preyx      <= preyx_nxt;
      preyy      <= preyy_nxt;
      fail       <= fail_nxt;
    end
  end

endmodule
